// File: rtl/uart_pkg.sv
// Shared definitions for the serial program loader: FSM state encoding,
// frame-format constants and the default inter-byte timeout.
// No ports; imported by uart_loader.
package uart_pkg;

  // LEN_HI keeps its encoding slot, but the FSM never rests there.
  // The first length byte is consumed straight from IDLE/DONE/ERROR.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  localparam int CHECKSUM_WIDTH         = 8;
  localparam int LEN_BYTES              = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/uart_loader.sv
// Loads a framed program image from the UART receiver into RAM.
// Frame layout: 16-bit big-endian word count N, N big-endian words, 8-bit data-byte sum.
// Ports:
//   clk, rst (synchronous, active-high)
//   rx_busy, rx_data: a byte is complete on the rx_busy falling edge
//   mem_we/mem_addr/mem_wdata: one-cycle RAM write strobe, address and data
//   loading/done/error: frame in progress / last frame good / last frame aborted
module uart_loader
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_busy,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  loading,
  output logic                  done,
  output logic                  error
);

  // The word counter is one bit wider than the address so that N = 2^ADDR_WIDTH
  // can be counted without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [63:0]     MAX_WORDS = 64'd1 << ADDR_WIDTH;

  state_e                      state_q, state_d;
  logic                        busy_q;
  logic [7:0]                  hi_q, hi_d;   // length high byte, then data high byte
  logic [CNT_W-1:0]            len_q, len_d;
  logic [CNT_W-1:0]            wcnt_q, wcnt_d;
  logic [CHECKSUM_WIDTH-1:0]   csum_q, csum_d;
  logic [TO_W-1:0]             to_q, to_d;
  logic                        mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [15:0]                 mem_wdata_q, mem_wdata_d;
  logic                        loading_q, loading_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;

  logic        byte_stb;
  logic [15:0] len16;
  logic        in_frame;

  assign byte_stb = busy_q & ~rx_busy;
  assign len16    = {hi_q, rx_data};
  assign in_frame = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
                    (state_q == S_DATA_LO) || (state_q == S_CHECK);

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    csum_d      = csum_q;
    to_d        = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    loading_d   = loading_q;
    done_d      = done_q;
    error_d     = error_q;

    // Inter-byte watchdog. It only fires when no byte arrives in the same
    // cycle, so a byte landing on the terminal count always wins.
    if (in_frame && !byte_stb) begin
      if (to_q == TO_LAST) begin
        state_d   = S_ERROR;
        error_d   = 1'b1;
        loading_d = 1'b0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    if (byte_stb) begin
      unique case (state_q)
        S_IDLE, S_LEN_HI, S_DONE, S_ERROR: begin
          hi_d      = rx_data;
          done_d    = 1'b0;
          error_d   = 1'b0;
          csum_d    = '0;
          wcnt_d    = '0;
          loading_d = 1'b1;
          state_d   = S_LEN_LO;
        end
        S_LEN_LO: begin
          if ({48'd0, len16} > MAX_WORDS) begin
            state_d   = S_ERROR;
            error_d   = 1'b1;
            loading_d = 1'b0;
          end else begin
            len_d   = CNT_W'(len16);
            state_d = (len16 == 16'd0) ? S_CHECK : S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          csum_d      = csum_q + rx_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
          mem_wdata_d = {hi_q, rx_data};
          wcnt_d      = wcnt_q + 1'b1;
          state_d     = (wcnt_d == len_q) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          loading_d = 1'b0;
          if (rx_data == csum_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      csum_q      <= '0;
      to_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= rx_busy;
      hi_q        <= hi_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      csum_q      <= csum_d;
      to_q        <= to_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign loading   = loading_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Randomized scoreboard bench for uart_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=100).
// Expected RAM writes are queued by a frame-level reference model; a monitor pops them on mem_we.
// Frame-end flags, timeout and reset behaviour are checked by the stimulus thread.
module tb_uart_loader;
  localparam int AW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          loading, done, error;

  uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_busy(rx_busy), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .loading(loading), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the head of the expected queue.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0h data %0h expected=no write", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(w.addr));
        check("write_data", 32'(mem_wdata), 32'(w.data));
      end
    end
  end

  // Reference model at frame level: decides which words reach RAM and the final flags.
  task automatic model_frame(input logic [7:0] bq[$], input bit timed_out,
                             output bit e_done, output bit e_err);
    int n, sum;
    e_done = 0;
    e_err  = 1;
    if (bq.size() < 2) return;
    n = bq[0] * 256 + bq[1];
    if (n > (1 << AW)) return;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (2 + 2*i + 1 < bq.size()) begin
        wr_t w;
        w.addr = i;
        w.data = bq[2+2*i] * 256 + bq[3+2*i];
        exp_q.push_back(w);
      end
      if (2 + 2*i + 1 < bq.size()) sum += bq[2+2*i] + bq[3+2*i];
    end
    if (timed_out || bq.size() < 2*n + 3) return;
    if (bq[2+2*n] == (sum % 256)) begin
      e_done = 1;
      e_err  = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    rx_busy = 1'b1;
    rx_data = b;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    rx_busy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] bq[$], input bit timed_out, input string tag);
    bit e_done, e_err;
    int n;
    model_frame(bq, timed_out, e_done, e_err);
    n = (bq.size() >= 2) ? bq[0] * 256 + bq[1] : 0;
    for (int i = 0; i < bq.size(); i++) begin
      if (i == bq.size() - 1 && i > 0) check({tag, "_loading_before_last"}, 32'(loading), 32'd1);
      send_byte(bq[i]);
    end
    if (timed_out) begin
      repeat (90) @(posedge clk);
      #1;
      check({tag, "_error_before_timeout"}, 32'(error), 32'd0);
      check({tag, "_loading_before_timeout"}, 32'(loading), 32'd1);
      repeat (15) @(posedge clk);
      #1;
    end
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_error"}, 32'(error), 32'(e_err));
    check({tag, "_loading"}, 32'(loading), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    if (e_done && n > 0) check({tag, "_addr_hold"}, 32'(mem_addr), 32'(n - 1));
  endtask

  task automatic run_random(input int idx);
    logic [7:0] bq[$];
    int n, kind, sum, cut;
    bit tout;
    n = $urandom_range(0, 1 << AW);
    kind = $urandom_range(0, 99);
    tout = 0;
    if (kind < 15) begin
      n = $urandom_range((1 << AW) + 1, 65535);
      bq.push_back(8'(n >> 8));
      bq.push_back(8'(n));
    end else begin
      bq.push_back(8'(n >> 8));
      bq.push_back(8'(n));
      sum = 0;
      for (int i = 0; i < 2*n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        bq.push_back(b);
        sum += b;
      end
      if (kind < 35) bq.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
      else bq.push_back(8'(sum));
      if (kind >= 35 && kind < 50) begin
        tout = 1;
        cut = $urandom_range(1, bq.size() - 1);
        while (bq.size() > cut) void'(bq.pop_back());
      end
    end
    run_frame(bq, tout, $sformatf("rand%0d", idx));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bq[$];
    int sum;

    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_wdata", 32'(mem_wdata), 32'd0);
    check("reset_flags", {29'd0, loading, done, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    run_frame(bq, 0, "two_words");
    bq = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    run_frame(bq, 0, "bad_sum");
    bq = '{8'h00, 8'h00, 8'h00};
    run_frame(bq, 0, "empty");
    bq = '{8'h00, 8'h11};
    run_frame(bq, 0, "too_long");

    bq = '{8'h00, 8'h10};
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      bq.push_back(b);
      sum += b;
    end
    bq.push_back(8'(sum));
    run_frame(bq, 0, "full_16");

    bq = '{8'h00, 8'h02, 8'h12};
    run_frame(bq, 1, "timeout");
    bq = '{8'h00, 8'h01, 8'h00, 8'h05, 8'h05};
    run_frame(bq, 0, "after_timeout");

    // Reset coinciding with the low data byte: the byte is lost, no write follows.
    bq = '{8'h00, 8'h02, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h84};
    run_frame(bq, 0, "pre_reset");
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    @(negedge clk);
    rx_busy = 1'b1;
    rx_data = 8'h34;
    repeat (2) @(negedge clk);
    rx_busy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_flags", {29'd0, loading, done, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_idle_flags", {29'd0, loading, done, error}, 32'd0);

    for (int i = 0; i < 40; i++) run_random(i);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
